// File: rtl/candidate_stream_seq.sv
// Candidate adder sequencer: buffers a job's bits, replays them three lanes per cycle,
// then returns the adder's final candidate. Optional LOAD watchdog via CAND_SEQ_TIMEOUT_EN.
module candidate_stream_seq #(
  parameter int MAX_LEN = 63
`ifdef CAND_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [5:0] cmd_len,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic [2:0] bit_data,
  output logic       en,
  output logic [5:0] now_0,
  output logic       count,
  output logic [1:0] reg_mode,
  output logic       result_0,
  output logic       result_1,
  output logic       result_2,
  input  logic [7:0] candidate,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       err
);

  localparam int BUF_W = MAX_LEN + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [5:0]       len_q, len_d;
  logic [5:0]       wr_cnt_q, wr_cnt_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             bit_ready_q, bit_ready_d;
  logic             en_q, en_d;
  logic [5:0]       now_q, now_d;
  logic             count_q, count_d;
  logic [2:0]       lanes_q, lanes_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [5:0]       load_rem;
  logic [5:0]       wr_idx;
  logic [BUF_W-1:0] buf_new;
`ifdef CAND_SEQ_TIMEOUT_EN
  logic [7:0]       to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
`endif

  function automatic logic [2:0] lane_mask(input logic [5:0] rem);
    if (rem >= 6'd3)      return 3'b111;
    else if (rem == 6'd2) return 3'b011;
    else if (rem == 6'd1) return 3'b001;
    else                  return 3'b000;
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    wr_cnt_d    = wr_cnt_q;
    buf_d       = buf_q;
    cmd_ready_d = cmd_ready_q;
    bit_ready_d = bit_ready_q;
    en_d        = en_q;
    now_d       = now_q;
    count_d     = count_q;
    lanes_d     = lanes_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
`ifdef CAND_SEQ_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    err_d       = 1'b0;
`endif

    // Only bits still owed by the job are written; surplus lanes of the last group are dropped.
    load_rem = len_q - wr_cnt_q;
    buf_new  = buf_q;
    wr_idx   = wr_cnt_q;
    for (int i = 0; i < 3; i++) begin
      wr_idx = wr_cnt_q + 6'(i);
      if (6'(i) < load_rem) buf_new[wr_idx] = bit_data[i];
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          mode_d      = cmd_mode;
          len_d       = cmd_len;
          wr_cnt_d    = '0;
          buf_d       = '0;
          cmd_ready_d = 1'b0;
`ifdef CAND_SEQ_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
          if (cmd_len == 6'd0) begin
            state_d = S_FLUSH;
            en_d    = 1'b1;
            now_d   = '0;
            count_d = 1'b0;
            lanes_d = '0;
          end else begin
            state_d     = S_LOAD;
            bit_ready_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (bit_valid) begin
          buf_d    = buf_new;
          wr_cnt_d = wr_cnt_q + 6'd3;
`ifdef CAND_SEQ_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          // The last group goes straight out as the first replay group to avoid a bubble.
          if (load_rem <= 6'd3) begin
            state_d     = S_RUN;
            bit_ready_d = 1'b0;
            en_d        = 1'b1;
            count_d     = 1'b1;
            now_d       = len_q;
            lanes_d     = buf_new[2:0] & lane_mask(len_q);
            buf_d       = buf_new >> 3;
          end
        end
`ifdef CAND_SEQ_TIMEOUT_EN
        else if (to_cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d     = S_IDLE;
          bit_ready_d = 1'b0;
          cmd_ready_d = 1'b1;
          err_d       = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
`endif
      end
      S_RUN: begin
        count_d = 1'b0;
        if (now_q <= 6'd3) begin
          state_d = S_FLUSH;
          now_d   = '0;
          lanes_d = '0;
        end else begin
          now_d   = now_q - 6'd3;
          lanes_d = buf_q[2:0] & lane_mask(now_q - 6'd3);
          buf_d   = buf_q >> 3;
        end
      end
      S_FLUSH: begin
        state_d     = S_DONE;
        en_d        = 1'b0;
        res_valid_d = 1'b1;
        res_data_d  = candidate;
      end
      S_DONE: begin
        if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      len_q       <= '0;
      wr_cnt_q    <= '0;
      buf_q       <= '0;
      cmd_ready_q <= 1'b1;
      bit_ready_q <= 1'b0;
      en_q        <= 1'b0;
      now_q       <= '0;
      count_q     <= 1'b0;
      lanes_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
`ifdef CAND_SEQ_TIMEOUT_EN
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      wr_cnt_q    <= wr_cnt_d;
      buf_q       <= buf_d;
      cmd_ready_q <= cmd_ready_d;
      bit_ready_q <= bit_ready_d;
      en_q        <= en_d;
      now_q       <= now_d;
      count_q     <= count_d;
      lanes_q     <= lanes_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
`ifdef CAND_SEQ_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign bit_ready = bit_ready_q;
  assign en        = en_q;
  assign now_0     = now_q;
  assign count     = count_q;
  assign reg_mode  = mode_q;
  assign result_0  = lanes_q[0];
  assign result_1  = lanes_q[1];
  assign result_2  = lanes_q[2];
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
`ifdef CAND_SEQ_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_candidate_stream_seq.sv
// Bench for candidate_stream_seq paired with a popcount-accumulating adder model.
// Timeout scenario compiles in only when CAND_SEQ_TIMEOUT_EN is defined.
module tb_candidate_stream_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_mode;
  logic [5:0] cmd_len;
  logic       bit_valid, bit_ready;
  logic [2:0] bit_data;
  logic       en;
  logic [5:0] now_0;
  logic       count;
  logic [1:0] reg_mode;
  logic       result_0, result_1, result_2;
  logic [7:0] candidate;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  int tick  = 0;

  logic [9:0] obs_rec[$];
  int         obs_latency;
  logic [7:0] obs_res;
  logic [1:0] obs_mode;
  bit         obs_done, obs_en_gap, obs_bitready_seen, obs_hold_bad;
  logic [1:0] obs_rel;
  logic [4:0] obs_rst;

  candidate_stream_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_data(bit_data),
    .en(en), .now_0(now_0), .count(count), .reg_mode(reg_mode),
    .result_0(result_0), .result_1(result_1), .result_2(result_2),
    .candidate(candidate),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err)
  );

  always #5 clk = ~clk;

  // Adder model: accumulates the number of set lanes while enabled, clears when idle.
  always @(posedge clk) begin
    if (rst || !en) candidate <= 8'd0;
    else candidate <= candidate + {7'd0, result_0} + {7'd0, result_1} + {7'd0, result_2};
  end

  function automatic int popcount(input logic [62:0] bits, input int len);
    int s = 0;
    for (int i = 0; i < len; i++) s += int'(bits[i]);
    return s;
  endfunction

  // Expected {now_0, count, result_2, result_1, result_0} for enabled cycle g (g == groups is FLUSH).
  function automatic logic [9:0] exp_rec(input logic [62:0] bits, input int len, input int g);
    int k = (len + 2) / 3;
    logic [2:0] l = '0;
    if (g >= k) return 10'd0;
    for (int i = 0; i < 3; i++)
      if (3 * g + i < len) l[i] = bits[3 * g + i];
    return {6'(len - 3 * g), (g == 0) ? 1'b1 : 1'b0, l};
  endfunction

  task automatic step();
    @(negedge clk);
    tick++;
  endtask

  task automatic drive_job(input logic [1:0] mode, input int len, input logic [62:0] bits,
                           input bit gaps, input int hold, input int pad, input int rst_after);
    int n_grp = (len + 2) / 3;
    int g = 0;
    int acc_tick;
    int en_seen = 0;
    bit en_ended = 0;
    bit go;
    logic [2:0] d;
    obs_rec.delete();
    obs_done = 0; obs_en_gap = 0; obs_bitready_seen = 0; obs_hold_bad = 0;
    obs_latency = -1; obs_res = 8'hxx; obs_mode = 2'bxx; obs_rel = 2'bxx; obs_rst = 5'bxxxxx;
    cmd_valid = 1'b1; cmd_mode = mode; cmd_len = 6'(len);
    acc_tick = tick;
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < 2000 && g < n_grp; c++) begin
      go = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (bit_ready && go) begin
        for (int i = 0; i < 3; i++) begin
          if (3 * g + i < len) d[i] = bits[3 * g + i];
          else d[i] = (pad == 0) ? 1'b0 : (pad == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        bit_valid = 1'b1; bit_data = d;
        g++;
        if (g == n_grp) acc_tick = tick;
      end else begin
        bit_valid = 1'b0; bit_data = 3'($urandom);
      end
      step();
    end
    bit_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bit_ready) obs_bitready_seen = 1;
      if (en) begin
        if (en_ended) obs_en_gap = 1;
        obs_rec.push_back({now_0, count, result_2, result_1, result_0});
        en_seen++;
        if (rst_after > 0 && en_seen == rst_after) begin
          rst = 1'b1;
          step();
          obs_rst = {en, cmd_ready, bit_ready, res_valid, err};
          rst = 1'b0;
          return;
        end
      end else if (en_seen > 0) begin
        en_ended = 1;
      end
      if (res_valid) begin
        obs_done = 1; obs_latency = tick - acc_tick; obs_res = res_data; obs_mode = reg_mode;
        break;
      end
      step();
    end
    if (!obs_done) return;
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      if (res_valid !== 1'b1 || res_data !== obs_res || cmd_ready !== 1'b0) obs_hold_bad = 1;
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    obs_rel = {res_valid, cmd_ready};
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_len = '0;
    bit_valid = 1'b0; bit_data = '0; res_ready = 1'b0;
    step(); step();
    n_cmp++;
    if ({cmd_ready, bit_ready, en, count, res_valid} !== 5'b10000) begin
      n_bad++; $display("[TB] FAIL reset_ctrl: got %b want 10000", {cmd_ready, bit_ready, en, count, res_valid});
    end
    n_cmp++;
    if ({now_0, reg_mode, result_0, result_1, result_2, res_data, err} !== 20'd0) begin
      n_bad++; $display("[TB] FAIL reset_data: got %h want 0", {now_0, reg_mode, result_0, result_1, result_2, res_data, err});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_len6();
    logic [9:0] got;
    drive_job(2'b00, 6, 63'b011101, 0, 0, 0, 0);
    n_cmp++;
    if (obs_rec.size() !== 3) begin n_bad++; $display("[TB] FAIL len6_en_cycles: got %0d want 3", obs_rec.size()); end
    got = (obs_rec.size() > 0) ? obs_rec[0] : 10'h3ff;
    n_cmp++;
    if (got !== {6'd6, 1'b1, 3'b101}) begin n_bad++; $display("[TB] FAIL len6_grp0: got %h want %h", got, {6'd6, 1'b1, 3'b101}); end
    got = (obs_rec.size() > 1) ? obs_rec[1] : 10'h3ff;
    n_cmp++;
    if (got !== {6'd3, 1'b0, 3'b011}) begin n_bad++; $display("[TB] FAIL len6_grp1: got %h want %h", got, {6'd3, 1'b0, 3'b011}); end
    n_cmp++;
    if (obs_res !== 8'd4) begin n_bad++; $display("[TB] FAIL len6_res: got %0d want 4", obs_res); end
    n_cmp++;
    if (obs_latency !== 4) begin n_bad++; $display("[TB] FAIL len6_latency: got %0d want 4", obs_latency); end
    n_cmp++;
    if (obs_rel !== 2'b01) begin n_bad++; $display("[TB] FAIL len6_release: got %b want 01", obs_rel); end
  endtask

  task automatic test_len4_mask();
    logic [9:0] got;
    drive_job(2'b00, 4, 63'b1111, 0, 0, 1, 0);
    got = (obs_rec.size() > 1) ? obs_rec[1] : 10'h3ff;
    n_cmp++;
    if (got !== {6'd1, 1'b0, 3'b001}) begin n_bad++; $display("[TB] FAIL len4_grp1_mask: got %h want %h", got, {6'd1, 1'b0, 3'b001}); end
    n_cmp++;
    if (obs_res !== 8'd4) begin n_bad++; $display("[TB] FAIL len4_res: got %0d want 4", obs_res); end
  endtask

  task automatic test_len0();
    drive_job(2'b10, 0, 63'd0, 0, 0, 2, 0);
    n_cmp++;
    if (obs_bitready_seen !== 1'b0) begin n_bad++; $display("[TB] FAIL len0_bit_ready: got 1 want 0"); end
    n_cmp++;
    if (obs_rec.size() !== 1) begin n_bad++; $display("[TB] FAIL len0_flush_cycles: got %0d want 1", obs_rec.size()); end
    n_cmp++;
    if ({obs_res, obs_mode} !== {8'd0, 2'b10}) begin n_bad++; $display("[TB] FAIL len0_res_mode: got %h want %h", {obs_res, obs_mode}, {8'd0, 2'b10}); end
    n_cmp++;
    if (obs_latency !== 2) begin n_bad++; $display("[TB] FAIL len0_latency: got %0d want 2", obs_latency); end
  endtask

  task automatic test_gaps();
    logic [62:0] bits = 63'({$urandom(), $urandom()});
    logic [7:0] ref_res;
    drive_job(2'b01, 30, bits, 0, 0, 2, 0);
    ref_res = obs_res;
    drive_job(2'b01, 30, bits, 1, 0, 2, 0);
    n_cmp++;
    if (obs_en_gap !== 1'b0 || obs_rec.size() !== 11) begin
      n_bad++; $display("[TB] FAIL gaps_contiguous: got gap=%0d cycles=%0d want gap=0 cycles=11", obs_en_gap, obs_rec.size());
    end
    n_cmp++;
    if (obs_res !== ref_res || obs_res !== 8'(popcount(bits, 30))) begin
      n_bad++; $display("[TB] FAIL gaps_res: got %0d want %0d", obs_res, popcount(bits, 30));
    end
    n_cmp++;
    if (obs_latency !== 12) begin n_bad++; $display("[TB] FAIL gaps_latency: got %0d want 12", obs_latency); end
  endtask

  task automatic test_backpressure();
    logic [62:0] bits = 63'({$urandom(), $urandom()});
    drive_job(2'b11, 7, bits, 0, 5, 2, 0);
    n_cmp++;
    if (obs_hold_bad !== 1'b0) begin n_bad++; $display("[TB] FAIL hold_stable: got unstable want stable"); end
    n_cmp++;
    if (obs_rel !== 2'b01) begin n_bad++; $display("[TB] FAIL hold_release: got %b want 01", obs_rel); end
    n_cmp++;
    if (obs_res !== 8'(popcount(bits, 7))) begin n_bad++; $display("[TB] FAIL hold_res: got %0d want %0d", obs_res, popcount(bits, 7)); end
  endtask

  task automatic test_reset_mid_run();
    logic [62:0] bits = 63'({$urandom(), $urandom()});
    drive_job(2'b01, 15, bits, 0, 0, 2, 2);
    n_cmp++;
    if (obs_rst !== 5'b01000) begin n_bad++; $display("[TB] FAIL rst_mid_run: got %b want 01000", obs_rst); end
    bits = 63'({$urandom(), $urandom()});
    drive_job(2'b10, 12, bits, 0, 0, 2, 0);
    n_cmp++;
    if (obs_res !== 8'(popcount(bits, 12)) || obs_mode !== 2'b10) begin
      n_bad++; $display("[TB] FAIL rst_next_job: got %0d/%b want %0d/10", obs_res, obs_mode, popcount(bits, 12));
    end
  endtask

`ifdef CAND_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int t0, seen_at = -1, err_cnt = 0;
    bit bad = 0;
    cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_len = 6'd9;
    step();
    cmd_valid = 1'b0;
    bit_valid = 1'b1; bit_data = 3'b111; t0 = tick;
    step();
    bit_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (err) begin err_cnt++; if (seen_at < 0) seen_at = tick - t0; end
      if (en || res_valid) bad = 1;
      step();
    end
    n_cmp++;
    if (seen_at !== 256 || err_cnt !== 1) begin
      n_bad++; $display("[TB] FAIL timeout_err: got at=%0d n=%0d want at=256 n=1", seen_at, err_cnt);
    end
    n_cmp++;
    if (bad !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL timeout_idle: got bad=%0d cmd_ready=%b want 0/1", bad, cmd_ready);
    end
  endtask
`else
  task automatic test_no_timeout();
    bit err_seen = 0, done = 0;
    logic [7:0] got = 8'hxx;
    cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_len = 6'd9;
    step();
    cmd_valid = 1'b0;
    bit_valid = 1'b1; bit_data = 3'b111;
    step();
    bit_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (err) err_seen = 1;
      step();
    end
    bit_valid = 1'b1; bit_data = 3'b010;
    step();
    bit_data = 3'b101;
    step();
    bit_valid = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (err) err_seen = 1;
      if (res_valid) begin done = 1; got = res_data; end
      else step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_cmp++;
    if (got !== 8'd6) begin n_bad++; $display("[TB] FAIL long_wait_res: got %0d want 6", got); end
    n_cmp++;
    if (err_seen !== 1'b0) begin n_bad++; $display("[TB] FAIL long_wait_err: got 1 want 0"); end
  endtask
`endif

  task automatic test_random();
    for (int j = 0; j < 20; j++) begin
      int len = $urandom_range(0, 63);
      int k = (len + 2) / 3;
      logic [1:0] mode = 2'($urandom);
      logic [62:0] bits = 63'({$urandom(), $urandom()});
      drive_job(mode, len, bits, $urandom_range(0, 1) == 1, $urandom_range(0, 3), 2, 0);
      n_cmp++;
      if ({obs_res, obs_mode} !== {8'(popcount(bits, len)), mode}) begin
        n_bad++; $display("[TB] FAIL rnd%0d_res_mode: got %0d/%b want %0d/%b", j, obs_res, obs_mode, popcount(bits, len), mode);
      end
      n_cmp++;
      if (obs_latency !== k + 2 || obs_rec.size() !== k + 1) begin
        n_bad++; $display("[TB] FAIL rnd%0d_timing: got lat=%0d en=%0d want lat=%0d en=%0d", j, obs_latency, obs_rec.size(), k + 2, k + 1);
      end
      for (int g = 0; g < obs_rec.size() && g <= k; g++) begin
        n_cmp++;
        if (obs_rec[g] !== exp_rec(bits, len, g)) begin
          n_bad++; $display("[TB] FAIL rnd%0d_grp%0d: got %h want %h", j, g, obs_rec[g], exp_rec(bits, len, g));
        end
      end
      n_cmp++;
      if (obs_hold_bad !== 1'b0 || obs_rel !== 2'b01) begin
        n_bad++; $display("[TB] FAIL rnd%0d_handshake: got hold_bad=%0d rel=%b want 0/01", j, obs_hold_bad, obs_rel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_len6();
    test_len4_mask();
    test_len0();
    test_gaps();
    test_backpressure();
    test_reset_mid_run();
`ifdef CAND_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
